mv_product_stage: RTL
=====================

Name: mv_product_stage

Overview:
- Operand-load and multiply stage directly upstream of the 6x6 row adder tree in the M6x6x2e12_V6x2e6 matrix-vector engine.
- Accepts a 6x6 matrix of 12-bit elements and a 6-element vector of 6-bit elements as a streamed word sequence.
- Forms all 36 products column by column and presents them as one 1152-bit bus in the adder tree's layout.
- Holds that bus stable until the consumer acknowledges it.

Parameters:
- N, 6, matrix dimension and vector length (fixed at 6 for this build).
- MAT_W, 12, matrix element width in bits.
- VEC_W, 6, vector element width in bits.
- PROD_W, 32, product slot width on the output bus.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand word valid.
- in_ready  output  1  stage can accept an operand word.
- in_data  input  32  operand word; element in low MAT_W bits (matrix phase) or low VEC_W bits (vector phase); upper bits ignored.
- prod_valid  output  1  M1152 holds a complete, stable product set.
- prod_ack  input  1  consumer has captured M1152; release the stage.
- M1152  output  1152  product bus; product M[i][j]*V[j] at bit offset PROD_W*(N*j+i), width PROD_W.

Behaviour:
- Clocking and reset:
  - One clock (clk).
  - Reset is synchronous and active-high (rst).
  - During reset the stage enters LOAD_M with word counter 0 and column counter 0.
  - Reset values: in_ready=0 during the reset cycle, then 1; prod_valid=0; M1152=0; matrix and vector registers=0.
  - Reset mid-operation, in any state, discards everything and returns to LOAD_M.
- Handshake: a word transfers when in_valid && in_ready are both high at a clock edge.
- States:
  - LOAD_M: in_ready=1. Word k (0..35) is written to M[k/6][k%6], row-major. After word 35 transfers, go to LOAD_V.
  - LOAD_V: in_ready=1. Word k (0..5) is written to V[k]. After word 5 transfers, go to MUL with col=0.
  - MUL: in_ready=0. Each cycle, col j computes P[i][j]=M[i][j]*V[j] for i=0..5 using 6 multipliers, registered into the slots for column j. col increments; after col=5 is written, go to HOLD.
  - HOLD: prod_valid=1, in_ready=0, M1152 frozen. On prod_ack=1, go to LOAD_M next cycle with prod_valid=0 and counters cleared.
- Timing:
  - Latency from the last vector word transfer to prod_valid=1 is 7 cycles: 6 MUL cycles plus 1 registration into HOLD.
  - M1152 keeps its last product set through LOAD_M, LOAD_V and MUL. Slots change only column by column during MUL.
- Arithmetic:
  - MAT_W x VEC_W gives an 18-bit product, extended to PROD_W.
  - Default is unsigned: zero-extend.
  - No overflow is possible.
- Boundary conditions:
  - prod_ack outside HOLD is ignored.
  - in_valid while in_ready=0 is ignored; no word is consumed.
  - prod_ack asserted in the same cycle HOLD is entered is honoured on the next cycle only. HOLD lasts at least 1 cycle.
  - Back-to-back loads are accepted at one word per cycle with no bubbles.

Optional Feature:
- Macro: MV_SIGNED_MUL_EN.
- Defined: M and V elements are two's-complement. Products are computed signed and sign-extended to PROD_W. Example: M=-1 (0xFFF), V=-2 (0x3E) gives 0x00000002.
- Undefined: unsigned multiply with zero-extension. Same inputs give 4095*62=253890=0x0003DFC2.

Decomposition:
- Shared package mv_pkg holds:
  - N, MAT_W, VEC_W, PROD_W and the derived bus widths 1152 and 192;
  - the state enum {LOAD_M, LOAD_V, MUL, HOLD};
  - a function returning the slot offset PROD_W*(N*j+i).
- One sub-module, mv_col_mul: N parallel MAT_W x VEC_W multipliers, one column per cycle, signedness selected by MV_SIGNED_MUL_EN.
- FSM, counters and operand/product registers stay in the top.

Test Plan:
- Identity matrix (M[i][i]=1, others 0), V={1,2,3,4,5,6}, unsigned: slot(i,i)=i+1, all other slots 0; prod_valid rises exactly 7 cycles after the last V word.
- All M=4095, all V=63, unsigned: every slot = 0x0003EFC1; HOLD persists for 20 cycles with prod_ack=0 and M1152 unchanged.
- in_valid toggling every other cycle during load: exactly 42 words consumed; in_ready=0 throughout MUL and HOLD; extra words offered in HOLD are not consumed.
- rst asserted at col=3 of MUL: next cycle shows prod_valid=0, M1152=0, in_ready=1, and a fresh 42-word load then completes correctly.
- prod_ack in HOLD followed by an immediate back-to-back second load with different data: M1152 retains the first products until the MUL phase of the second load; the second set is correct.
- With MV_SIGNED_MUL_EN defined, M[0][0]=0xFFF, V[0]=0x3E: slot(0,0)=0x00000002. Without the macro: 0x0003DFC2.

Source files
------------

// File: rtl/mv_pkg.sv
// ============================================================================
// Module   : mv_pkg
// Purpose  : Shared sizes, state encoding and slot-offset helper for the
//            matrix-vector product stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mv_pkg;

    localparam int N         = 6;
    localparam int MAT_W     = 12;
    localparam int VEC_W     = 6;
    localparam int PROD_W    = 32;
    localparam int RAW_W     = MAT_W + VEC_W;
    localparam int COL_W     = N * PROD_W;          // 192
    localparam int BUS_W     = N * N * PROD_W;      // 1152
    localparam int MAT_BITS  = N * N * MAT_W;
    localparam int VEC_BITS  = N * VEC_W;
    localparam int CNT_W     = 6;
    localparam int COL_CNT_W = 3;

    typedef enum logic [1:0] {
        LOAD_M = 2'd0,
        LOAD_V = 2'd1,
        MUL    = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // Column-major slot layout expected by the downstream row adder tree.
    function automatic int slot_offset(input int i, input int j);
        return PROD_W * (N * j + i);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mv_col_mul.sv
// ============================================================================
// Module   : mv_col_mul
// Purpose  : N parallel MAT_W x VEC_W multipliers for one matrix column.
//            Define MV_SIGNED_MUL_EN for two's-complement operands.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mv_col_mul
    import mv_pkg::*;
(
    input  logic [N*MAT_W-1:0] i_m_col,
    input  logic [VEC_W-1:0]   i_v_elem,
    output logic [COL_W-1:0]   o_col_prod
);

`ifdef MV_SIGNED_MUL_EN
    localparam logic c_signed = 1'b1;
`else
    localparam logic c_signed = 1'b0;
`endif

    logic [RAW_W-1:0] w_v_ext;

    // Operands widened to the full product width so the low RAW_W bits of the
    // product are exact for both signed and unsigned interpretation.
    assign w_v_ext = {{MAT_W{c_signed & i_v_elem[VEC_W-1]}}, i_v_elem};

    generate
        for (genvar i = 0; i < N; i++) begin : g_mul
            logic [MAT_W-1:0] w_m;
            logic [RAW_W-1:0] w_m_ext;
            logic [RAW_W-1:0] w_prod;

            assign w_m     = i_m_col[i*MAT_W +: MAT_W];
            assign w_m_ext = {{VEC_W{c_signed & w_m[MAT_W-1]}}, w_m};
            assign w_prod  = w_m_ext * w_v_ext;
            assign o_col_prod[i*PROD_W +: PROD_W] =
                {{(PROD_W-RAW_W){c_signed & w_prod[RAW_W-1]}}, w_prod};
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/mv_product_stage.sv
// ============================================================================
// Module   : mv_product_stage
// Purpose  : Streams in a 6x6 matrix and 6-vector, forms all 36 products one
//            column per cycle and holds the 1152-bit bus until acknowledged.
//            Optional macro: MV_SIGNED_MUL_EN (signed operands).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mv_product_stage
    import mv_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_data,
    output logic               prod_valid,
    input  logic               prod_ack,
    output logic [BUS_W-1:0]   M1152
);

    localparam logic [CNT_W-1:0]     c_last_m = CNT_W'(N*N - 1);
    localparam logic [CNT_W-1:0]     c_last_v = CNT_W'(N - 1);
    localparam logic [COL_CNT_W-1:0] c_col_done = COL_CNT_W'(N);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [COL_CNT_W-1:0]   col_q, col_d;
    logic [MAT_BITS-1:0]    m_q, m_d;
    logic [VEC_BITS-1:0]    v_q, v_d;
    logic [BUS_W-1:0]       prod_q, prod_d;

    logic                   w_xfer;
    logic [N*MAT_W-1:0]     w_m_col;
    logic [VEC_W-1:0]       w_v_elem;
    logic [COL_W-1:0]       w_col_prod;
    logic                   w_unused;

    assign w_unused   = ^in_data[31:MAT_W];
    assign in_ready   = !rst && ((state_q == LOAD_M) || (state_q == LOAD_V));
    assign prod_valid = !rst && (state_q == HOLD);
    assign w_xfer     = in_valid && in_ready;
    assign M1152      = prod_q;

    // Column select; col_q == N is the registration cycle and selects nothing used.
    always_comb begin
        w_m_col  = '0;
        w_v_elem = '0;
        if (col_q < c_col_done) begin
            for (int i = 0; i < N; i++) begin
                w_m_col[i*MAT_W +: MAT_W] = m_q[(i*N + int'(col_q))*MAT_W +: MAT_W];
            end
            w_v_elem = v_q[int'(col_q)*VEC_W +: VEC_W];
        end
    end

    mv_col_mul u_col_mul (
        .i_m_col    (w_m_col),
        .i_v_elem   (w_v_elem),
        .o_col_prod (w_col_prod)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        col_d   = col_q;
        m_d     = m_q;
        v_d     = v_q;
        prod_d  = prod_q;

        case (state_q)
            LOAD_M: begin
                if (w_xfer) begin
                    m_d[int'(cnt_q)*MAT_W +: MAT_W] = in_data[MAT_W-1:0];
                    if (cnt_q == c_last_m) begin
                        cnt_d   = '0;
                        state_d = LOAD_V;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            LOAD_V: begin
                if (w_xfer) begin
                    v_d[int'(cnt_q)*VEC_W +: VEC_W] = in_data[VEC_W-1:0];
                    if (cnt_q == c_last_v) begin
                        cnt_d   = '0;
                        col_d   = '0;
                        state_d = MUL;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            MUL: begin
                // Six product cycles, then one cycle to register entry into HOLD.
                if (col_q == c_col_done) begin
                    col_d   = '0;
                    state_d = HOLD;
                end else begin
                    for (int i = 0; i < N; i++) begin
                        prod_d[slot_offset(i, int'(col_q)) +: PROD_W] =
                            w_col_prod[i*PROD_W +: PROD_W];
                    end
                    col_d = col_q + 1'b1;
                end
            end

            HOLD: begin
                if (prod_ack) begin
                    cnt_d   = '0;
                    col_d   = '0;
                    state_d = LOAD_M;
                end
            end

            default: state_d = LOAD_M;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD_M;
            cnt_q   <= '0;
            col_q   <= '0;
            m_q     <= '0;
            v_q     <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            m_q     <= m_d;
            v_q     <= v_d;
            prod_q  <= prod_d;
        end
    end

endmodule

`default_nettype wire
